// File: rtl/mem_dev5_reader_if.sv
// Transmit-side handshake between the buffer reader and the Manchester word encoder.
// MEM_DEV5_RD_PARITY_EN adds an odd-parity bit that travels with each word.
interface mem_dev5_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
`ifdef MEM_DEV5_RD_PARITY_EN
  logic                  tx_parity;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_parity,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_parity,
    output tx_ready
  );
`else
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
`endif
endinterface

// File: rtl/mem_dev5_reader.sv
// Read-side sequencer for the device-5 transmit buffer RAM: walks a block of words and
// hands each to the word encoder. Optional odd parity output under MEM_DEV5_RD_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for start
// ADDR    | RAM samples rdaddress this edge
// LOAD    | RAM q valid, capture into tx_data
// PRESENT | tx_valid high, waiting for tx_ready
module mem_dev5_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_cnt,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  busy,
  output logic                  done,
  mem_dev5_reader_if.master     tx_if
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR    = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  logic [1:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] rdaddress_q, rdaddress_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
  logic                  tx_valid_q,  tx_valid_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
`ifdef MEM_DEV5_RD_PARITY_EN
  logic                  tx_parity_q, tx_parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    rdaddress_d = rdaddress_q;
    remaining_d = remaining_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef MEM_DEV5_RD_PARITY_EN
    tx_parity_d = tx_parity_q;
`endif

    if (state_q != ST_IDLE && abort) begin
      // rdaddress and tx_data deliberately keep their last values
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            rdaddress_d = base_addr;
            // a zero word count means a full buffer of 2**ADDR_WIDTH words
            remaining_d = (word_cnt == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                           : {1'b0, word_cnt};
            busy_d      = 1'b1;
            state_d     = ST_ADDR;
          end
        end
        ST_ADDR: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_d   = q;
          tx_valid_d  = 1'b1;
`ifdef MEM_DEV5_RD_PARITY_EN
          tx_parity_d = ~(^q);
`endif
          state_d     = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (tx_valid_q && tx_if.tx_ready) begin
            tx_valid_d  = 1'b0;
            remaining_d = remaining_q - CNT_ONE;
            if (remaining_q > CNT_ONE) begin
              rdaddress_d = rdaddress_q + ADDR_ONE;
              state_d     = ST_ADDR;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdaddress_q <= '0;
      remaining_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_DEV5_RD_PARITY_EN
      tx_parity_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      rdaddress_q <= rdaddress_d;
      remaining_q <= remaining_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MEM_DEV5_RD_PARITY_EN
      tx_parity_q <= tx_parity_d;
`endif
    end
  end

  assign rdaddress      = rdaddress_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;
`ifdef MEM_DEV5_RD_PARITY_EN
  assign tx_if.tx_parity = tx_parity_q;
`endif

endmodule

// File: tb/tb_mem_dev5_reader.sv
// Bench for mem_dev5_reader: behavioural RAM plus a scoreboard of expected (address, word)
// pairs, popped at every observed transfer.
module tb_mem_dev5_reader;

  localparam int DW = 16;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_cnt = '0;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] ram [32];

  mem_dev5_reader_if #(.DATA_WIDTH(DW)) tx_if ();

  mem_dev5_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .rdaddress (rdaddress),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .tx_if     (tx_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q <= ram[rdaddress];

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;

  // Advance one clock; inputs for the coming edge are already driven, so the transfer
  // condition is known before the edge and the scoreboard is popped after it.
  task automatic step();
    logic xfer;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic p;
    exp_t e;
    xfer = tx_if.tx_valid && tx_if.tx_ready && !abort && rst_n;
    d = tx_if.tx_data;
    a = rdaddress;
`ifdef MEM_DEV5_RD_PARITY_EN
    p = tx_if.tx_parity;
`else
    p = 1'b0;
`endif
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (xfer) begin
      xfer_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL xfer_unexpected: got word %h at addr %0d, none expected", d, a);
      end else begin
        e = sb.pop_front();
        if (d !== e.d) begin
          miscompares++;
          $display("FAIL xfer_data: got %h expected %h", d, e.d);
        end
        vectors++;
        if (a !== e.a) begin
          miscompares++;
          $display("FAIL xfer_addr: got %0d expected %0d", a, e.a);
        end
`ifdef MEM_DEV5_RD_PARITY_EN
        vectors++;
        if (p !== e.p) begin
          miscompares++;
          $display("FAIL xfer_parity: got %b expected %b for word %h", p, e.p, e.d);
        end
`endif
      end
    end
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    ram[a] = d;
    e.a = a;
    e.d = d;
    e.p = ~(^d);
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (tx_if.tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (tx_if.tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: tx_valid=%b after %0d cycles, expected 1", name, tx_if.tx_valid, n);
    end
  endtask

  task automatic run_to_done(input string name, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL %s_done_timeout: done pulses=%0d expected 1", name, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (rdaddress !== '0 || tx_if.tx_data !== '0 || tx_if.tx_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdaddress=%0d tx_data=%h tx_valid=%b busy=%b done=%b, expected all 0",
               rdaddress, tx_if.tx_data, tx_if.tx_valid, busy, done);
    end
`ifdef MEM_DEV5_RD_PARITY_EN
    vectors++;
    if (tx_if.tx_parity !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_parity: got %b expected 1", tx_if.tx_parity);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int x0 = xfer_cnt;
    push_word(5'd4, 16'hA001);
    push_word(5'd5, 16'hA002);
    push_word(5'd6, 16'hA003);
    tx_if.tx_ready = 1'b1;
    base_addr = 5'd4;
    word_cnt = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rdaddress !== 5'd4 || tx_if.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_edge_e: busy=%b rdaddress=%0d tx_valid=%b, expected 1 4 0", busy, rdaddress, tx_if.tx_valid);
    end
    step();
    vectors++;
    if (tx_if.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_edge_e1: tx_valid=%b expected 0", tx_if.tx_valid);
    end
    step();
    vectors++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 16'hA001) begin
      miscompares++;
      $display("FAIL basic_edge_e2: tx_valid=%b tx_data=%h, expected 1 a001", tx_if.tx_valid, tx_if.tx_data);
    end
    run_to_done("basic", 40);
    vectors++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0 || xfer_cnt - x0 != 3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_end: busy=%b tx_valid=%b xfers=%0d left=%0d, expected 0 0 3 0",
               busy, tx_if.tx_valid, xfer_cnt - x0, sb.size());
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width: done=%b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_backpressure_wrap();
    logic [DW-1:0] hold;
    int d0 = done_cnt;
    push_word(5'd30, 16'(16'h3000 + $urandom_range(0, 4095)));
    push_word(5'd31, 16'(16'h4000 + $urandom_range(0, 4095)));
    push_word(5'd0,  16'(16'h5000 + $urandom_range(0, 4095)));
    push_word(5'd1,  16'(16'h6000 + $urandom_range(0, 4095)));
    tx_if.tx_ready = 1'b0;
    base_addr = 5'd30;
    word_cnt = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wait_valid("bp");
      hold = tx_if.tx_data;
      for (int k = 0; k < 5; k++) begin
        step();
        vectors++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== hold) begin
          miscompares++;
          $display("FAIL bp_hold: word %0d tx_valid=%b tx_data=%h, expected 1 %h", w, tx_if.tx_valid, tx_if.tx_data, hold);
        end
      end
      tx_if.tx_ready = 1'b1;
      step();
      tx_if.tx_ready = 1'b0;
    end
    vectors++;
    if (done !== 1'b1 || done_cnt != d0 + 1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_done: done=%b pulses=%0d left=%0d, expected 1 1 0", done, done_cnt - d0, sb.size());
    end
    step();
  endtask

  task automatic test_full_count();
    int x0 = xfer_cnt;
    int d0 = done_cnt;
    int n = 0;
    for (int i = 0; i < 32; i++) push_word(AW'(i), 16'($urandom));
    tx_if.tx_ready = 1'b1;
    base_addr = 5'd0;
    word_cnt = 5'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (done_cnt == d0 && n < 200) begin
      start = (busy === 1'b1) && (n % 5 == 2);
      step();
      n++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (xfer_cnt - x0 != 32 || done_cnt - d0 != 1 || sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_count: xfers=%0d dones=%0d left=%0d busy=%b, expected 32 1 0 0",
               xfer_cnt - x0, done_cnt - d0, sb.size(), busy);
    end
  endtask

  task automatic test_abort();
    int x0 = xfer_cnt;
    int d0 = done_cnt;
    int n = 0;
    for (int i = 0; i < 5; i++) push_word(AW'(20 + i), 16'($urandom));
    tx_if.tx_ready = 1'b1;
    base_addr = 5'd20;
    word_cnt = 5'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    while (xfer_cnt == x0 && n < 20) begin
      step();
      n++;
    end
    tx_if.tx_ready = 1'b0;
    wait_valid("abort");
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdaddress !== 5'd21) begin
      miscompares++;
      $display("FAIL abort_mid: tx_valid=%b busy=%b done=%b rdaddress=%0d, expected 0 0 0 21",
               tx_if.tx_valid, busy, done, rdaddress);
    end
    step();
    vectors++;
    if (done_cnt != d0 || xfer_cnt - x0 != 1) begin
      miscompares++;
      $display("FAIL abort_no_done: dones=%0d xfers=%0d, expected 0 1", done_cnt - d0, xfer_cnt - x0);
    end
    sb.delete();

    push_word(5'd10, 16'h1234);
    base_addr = 5'd10;
    word_cnt = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (rdaddress !== 5'd10 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart: rdaddress=%0d busy=%b, expected 10 1", rdaddress, busy);
    end
    tx_if.tx_ready = 1'b1;
    run_to_done("abort_restart", 20);
    step();

    base_addr = 5'd2;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rdaddress !== 5'd10) begin
      miscompares++;
      $display("FAIL abort_beats_start: busy=%b rdaddress=%0d, expected 0 10", busy, rdaddress);
    end

    d0 = done_cnt;
    push_word(5'd3, 16'hBEEF);
    tx_if.tx_ready = 1'b0;
    base_addr = 5'd3;
    word_cnt = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("abort_final");
    tx_if.tx_ready = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    tx_if.tx_ready = 1'b0;
    step();
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_beats_final: dones=%0d busy=%b tx_valid=%b, expected 0 0 0",
               done_cnt - d0, busy, tx_if.tx_valid);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    push_word(5'd8, 16'($urandom));
    push_word(5'd9, 16'($urandom));
    tx_if.tx_ready = 1'b1;
    base_addr = 5'd8;
    word_cnt = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("b2b_first", 30);
    push_word(5'd12, 16'($urandom));
    base_addr = 5'd12;
    word_cnt = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rdaddress !== 5'd12) begin
      miscompares++;
      $display("FAIL b2b_start_on_done: busy=%b rdaddress=%0d, expected 1 12", busy, rdaddress);
    end
    run_to_done("b2b_second", 20);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_left: %0d words not transferred, expected 0", sb.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_word(AW'(16 + i), 16'($urandom) | 16'h0100);
    tx_if.tx_ready = 1'b0;
    base_addr = 5'd16;
    word_cnt = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (rdaddress !== '0 || tx_if.tx_data !== '0 || tx_if.tx_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: rdaddress=%0d tx_data=%h tx_valid=%b busy=%b done=%b, expected all 0",
               rdaddress, tx_if.tx_data, tx_if.tx_valid, busy, done);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_word(5'd5, 16'hC0DE);
    base_addr = 5'd5;
    word_cnt = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rdaddress !== 5'd5) begin
      miscompares++;
      $display("FAIL rst_mid_restart: busy=%b rdaddress=%0d, expected 1 5", busy, rdaddress);
    end
    tx_if.tx_ready = 1'b1;
    run_to_done("rst_mid_restart", 20);
    step();
  endtask

`ifdef MEM_DEV5_RD_PARITY_EN
  task automatic test_parity();
    exp_t e;
    logic [DW-1:0] words [3];
    logic          pars  [3];
    words[0] = 16'h0000; pars[0] = 1'b1;
    words[1] = 16'h0001; pars[1] = 1'b0;
    words[2] = 16'hFFFF; pars[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ram[AW'(24 + i)] = words[i];
      e.a = AW'(24 + i);
      e.d = words[i];
      e.p = pars[i];
      sb.push_back(e);
    end
    tx_if.tx_ready = 1'b1;
    base_addr = 5'd24;
    word_cnt = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("parity", 30);
    step();
  endtask
`endif

  initial begin
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    test_reset();
    test_basic();
    test_backpressure_wrap();
    test_full_count();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_DEV5_RD_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_scoreboard: %0d expected words never transferred", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
